// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    // Request/response tracking state of the fetch engine.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    // Byte distance between consecutive 16-bit instructions.
    localparam logic [15:0] PC_STEP = 16'd2;

    // One prefetch queue entry: instruction word tagged with its PC.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
    } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two prefetch queue. Flush wins over push; head reads as zero when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  entry_t                   push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output entry_t                   head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    // Qualify push/pop: a flush cancels both, and an empty queue cannot pop.
    always_comb begin
        do_push = push_i && !flush_i;
        do_pop  = pop_i && (count_q != '0) && !flush_i;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Present the head, forced to zero when nothing is queued.
    always_comb begin
        head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
        count_o = count_q;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential request generation, prefetch queue,
// and redirect handling that flushes the queue and drops in-flight responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        en,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    input  logic        inst_ready
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e          state_q;
    logic [15:0]     fetch_pc_q;
    logic [15:0]     addr_q;
    logic [CW-1:0]   count;
    entry_t          head;
    entry_t          push_data;
    logic            issue;
    logic            push;
    logic            pop;

    // Request, push and pop decisions; a redirect suppresses both request and push.
    always_comb begin
        issue     = rst_n && (state_q == S_IDLE) && (count < DEPTH_C) && !redirect;
        push      = (state_q == S_WAIT) && imem_valid && !redirect;
        pop       = (count != '0) && inst_ready;
        push_data = '{pc: addr_q, inst: imem_rdata};
        imem_req  = issue;
        imem_addr = issue ? fetch_pc_q : addr_q;
        en        = (count != '0);
        inst      = head.inst;
        inst_pc   = head.pc;
    end

    // Fetch FSM with PC tracking; addr_q remembers the outstanding request's PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            if (issue) begin
                addr_q     <= fetch_pc_q;
                fetch_pc_q <= fetch_pc_q + PC_STEP;
            end
            if (redirect) fetch_pc_q <= redirect_pc & ~16'h0001;
            case (state_q)
                S_IDLE: if (issue) state_q <= S_WAIT;
                S_WAIT: begin
                    if (redirect)        state_q <= imem_valid ? S_IDLE : S_DROP;
                    else if (imem_valid) state_q <= S_IDLE;
                end
                // A response landing together with another redirect still retires the stale request.
                S_DROP: if (imem_valid) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (redirect),
        .count_o     (count),
        .head_o      (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven cycle vectors plus hand sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_valid, redirect, en, inst_ready;
    logic [15:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
    logic        imem_req2, imem_valid2, en2, redirect2, inst_ready2;
    logic [15:0] imem_addr2, imem_rdata2, inst2, inst_pc2, redirect_pc2;

    int n_chk = 0;
    int n_err = 0;
    int mem_lat = 1;

    fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .en(en), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    fetch_unit #(.RESET_PC(16'hFFFE), .DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_valid(imem_valid2), .imem_rdata(imem_rdata2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .en(en2), .inst(inst2), .inst_pc(inst_pc2),
        .inst_ready(inst_ready2)
    );

    always #5 clk = ~clk;

    // Memory model for dut: latency mem_lat, data word is the bitwise inverse of the address.
    initial begin
        logic        pend;
        int          cnt;
        logic [15:0] paddr;
        pend = 1'b0; cnt = 0; paddr = '0;
        imem_valid = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) pend = 1'b0;
            else if (imem_req) begin pend = 1'b1; cnt = mem_lat; paddr = imem_addr; end
            @(posedge clk); #1;
            imem_valid = 1'b0; imem_rdata = '0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin imem_valid = 1'b1; imem_rdata = ~paddr; pend = 1'b0; end
            end
        end
    end

    // Memory model for dut2: fixed latency 1, same data pattern.
    initial begin
        logic        pend;
        logic [15:0] paddr;
        pend = 1'b0; paddr = '0;
        imem_valid2 = 1'b0; imem_rdata2 = '0;
        redirect2 = 1'b0; redirect_pc2 = '0; inst_ready2 = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) pend = 1'b0;
            else if (imem_req2) begin pend = 1'b1; paddr = imem_addr2; end
            @(posedge clk); #1;
            imem_valid2 = pend; imem_rdata2 = pend ? ~paddr : '0;
            pend = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Hold reset for two edges, release 1 time unit after a rising edge (cycle 0 starts there).
    task automatic do_reset(input int lat, input logic rdy);
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
        inst_ready = rdy; mem_lat = lat;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        string       tag;
        logic        rst_before;
        int          lat;
        logic        redir;
        logic [15:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_en;
        logic [15:0] e_pc;
        logic [15:0] e_inst;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input string tag, input logic rb, input int lat, input logic rd,
                     input logic [15:0] rpc, input logic rdy, input logic req,
                     input logic [15:0] addr, input logic e, input logic [15:0] pc,
                     input logic [15:0] ins);
        vec_t x;
        x.tag = tag; x.rst_before = rb; x.lat = lat; x.redir = rd; x.rpc = rpc; x.rdy = rdy;
        x.e_req = req; x.e_addr = addr; x.e_en = e; x.e_pc = pc; x.e_inst = ins;
        vecs.push_back(x);
    endtask

    initial begin
        // seq: L=1, consumer always ready
        v("seq0", 1, 1, 0, 0, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        v("seq1", 0, 1, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        v("seq2", 0, 1, 0, 0, 1, 1, 16'h0002, 1, 16'h0000, 16'hFFFF);
        v("seq3", 0, 1, 0, 0, 1, 0, 16'h0002, 0, 16'h0000, 16'h0000);
        v("seq4", 0, 1, 0, 0, 1, 1, 16'h0004, 1, 16'h0002, 16'hFFFD);
        v("seq5", 0, 1, 0, 0, 1, 0, 16'h0004, 0, 16'h0000, 16'h0000);
        v("seq6", 0, 1, 0, 0, 1, 1, 16'h0006, 1, 16'h0004, 16'hFFFB);
        // stall: consumer blocked 10 cycles, queue fills at DEPTH
        v("stl0", 1, 1, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        v("stl1", 0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        v("stl2", 0, 1, 0, 0, 0, 1, 16'h0002, 1, 16'h0000, 16'hFFFF);
        for (int i = 3; i <= 9; i++)
            v($sformatf("stl%0d", i), 0, 1, 0, 0, 0, 0, 16'h0002, 1, 16'h0000, 16'hFFFF);
        v("stl10", 0, 1, 0, 0, 1, 0, 16'h0002, 1, 16'h0000, 16'hFFFF);
        v("stl11", 0, 1, 0, 0, 1, 1, 16'h0004, 1, 16'h0002, 16'hFFFD);
        v("stl12", 0, 1, 0, 0, 1, 0, 16'h0004, 0, 16'h0000, 16'h0000);
        v("stl13", 0, 1, 0, 0, 1, 1, 16'h0006, 1, 16'h0004, 16'hFFFB);
        // redirect while waiting, L=3: stale response dropped
        v("rdw0", 1, 3, 0, 0,        1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        v("rdw1", 0, 3, 1, 16'h0101, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        v("rdw2", 0, 3, 0, 0,        1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        v("rdw3", 0, 3, 0, 0,        1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        v("rdw4", 0, 3, 0, 0,        1, 1, 16'h0100, 0, 16'h0000, 16'h0000);
        v("rdw5", 0, 3, 0, 0,        1, 0, 16'h0100, 0, 16'h0000, 16'h0000);
        v("rdw6", 0, 3, 0, 0,        1, 0, 16'h0100, 0, 16'h0000, 16'h0000);
        v("rdw7", 0, 3, 0, 0,        1, 0, 16'h0100, 0, 16'h0000, 16'h0000);
        v("rdw8", 0, 3, 0, 0,        1, 1, 16'h0102, 1, 16'h0100, 16'hFEFF);
        // redirect coinciding with response, then redirect in IDLE with a queued word
        v("rdv0", 1, 1, 0, 0,        1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        v("rdv1", 0, 1, 1, 16'h0040, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        v("rdv2", 0, 1, 0, 0,        1, 1, 16'h0040, 0, 16'h0000, 16'h0000);
        v("rdv3", 0, 1, 0, 0,        1, 0, 16'h0040, 0, 16'h0000, 16'h0000);
        v("rdv4", 0, 1, 0, 0,        1, 1, 16'h0042, 1, 16'h0040, 16'hFFBF);
        v("rdv5", 0, 1, 0, 0,        1, 0, 16'h0042, 0, 16'h0000, 16'h0000);
        v("rdv6", 0, 1, 1, 16'h0201, 1, 0, 16'h0042, 1, 16'h0042, 16'hFFBD);
        v("rdv7", 0, 1, 0, 0,        1, 1, 16'h0200, 0, 16'h0000, 16'h0000);
        v("rdv8", 0, 1, 0, 0,        1, 0, 16'h0200, 0, 16'h0000, 16'h0000);
        v("rdv9", 0, 1, 0, 0,        1, 1, 16'h0202, 1, 16'h0200, 16'hFDFF);

        // Reset values while rst_n is held low
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
        @(negedge clk);
        chk("rst.req",   {15'd0, imem_req}, 16'h0000);
        chk("rst.addr",  imem_addr, 16'h0000);
        chk("rst.en",    {15'd0, en}, 16'h0000);
        chk("rst.inst",  inst, 16'h0000);
        chk("rst.pc",    inst_pc, 16'h0000);
        chk("rst.addr2", imem_addr2, 16'hFFFE);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset(vecs[i].lat, vecs[i].rdy);
            mem_lat     = vecs[i].lat;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            inst_ready  = vecs[i].rdy;
            @(negedge clk);
            chk({vecs[i].tag, ".req"},  {15'd0, imem_req}, {15'd0, vecs[i].e_req});
            chk({vecs[i].tag, ".addr"}, imem_addr, vecs[i].e_addr);
            chk({vecs[i].tag, ".en"},   {15'd0, en}, {15'd0, vecs[i].e_en});
            chk({vecs[i].tag, ".pc"},   inst_pc, vecs[i].e_pc);
            chk({vecs[i].tag, ".inst"}, inst, vecs[i].e_inst);
            step();
        end
        redirect = 1'b0; redirect_pc = '0;

        // RESET_PC = 0xFFFE: addresses wrap 0xFFFE -> 0x0000 -> 0x0002
        do_reset(1, 1'b1);
        @(negedge clk);
        chk("wrap.req0",  {15'd0, imem_req2}, 16'h0001);
        chk("wrap.addr0", imem_addr2, 16'hFFFE);
        step(); step();
        @(negedge clk);
        chk("wrap.addr1", imem_addr2, 16'h0000);
        chk("wrap.en1",   {15'd0, en2}, 16'h0001);
        chk("wrap.pc1",   inst_pc2, 16'hFFFE);
        chk("wrap.inst1", inst2, 16'h0001);
        step(); step();
        @(negedge clk);
        chk("wrap.req2",  {15'd0, imem_req2}, 16'h0001);
        chk("wrap.addr2", imem_addr2, 16'h0002);
        chk("wrap.pc2",   inst_pc2, 16'h0000);

        // Asynchronous reset mid-WAIT with one entry queued
        do_reset(3, 1'b0);
        step(); step(); step(); step();
        @(negedge clk);
        chk("arst.pre_en",  {15'd0, en}, 16'h0001);
        chk("arst.pre_req", {15'd0, imem_req}, 16'h0001);
        chk("arst.pre_adr", imem_addr, 16'h0002);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst.req",  {15'd0, imem_req}, 16'h0000);
        chk("arst.addr", imem_addr, 16'h0000);
        chk("arst.en",   {15'd0, en}, 16'h0000);
        chk("arst.inst", inst, 16'h0000);
        chk("arst.pc",   inst_pc, 16'h0000);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("arst.req1",  {15'd0, imem_req}, 16'h0001);
        chk("arst.addr1", imem_addr, 16'h0000);
        chk("arst.en1",   {15'd0, en}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the 16-bit core. It generates sequential instruction-memory read requests, buffers returned words with their PCs in a small prefetch queue, and presents them to the decoder as `inst`/`en` under a valid/ready handshake. Branch, jump, trap and return-from-interrupt redirects flush the queue and discard any in-flight response.

## Interface
- `RESET_PC`, 16'h0000: first fetch address after reset. Bit 0 must be 0.
- `DEPTH`, 2: prefetch queue entries. Must be a power of two and at least 2.
- `clk` in 1: single clock. All logic is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `imem_req` out 1: one-cycle read request strobe.
- `imem_addr` out 16: byte address of the request, always even.
- `imem_valid` in 1: read data valid.
- `imem_rdata` in 16: instruction word.
- `redirect` in 1: PC redirect from execute/trap logic.
- `redirect_pc` in 16: redirect target. Bit 0 is ignored and treated as 0.
- `en` out 1: instruction valid. Drives the decoder `en`.
- `inst` out 16: instruction word at the queue head.
- `inst_pc` out 16: PC of `inst`.
- `inst_ready` in 1: consumer accepts the head this cycle.

## Operation
- **Memory contract**
  - Memory accepts every `imem_req` immediately; there is no grant.
  - Memory returns exactly one `imem_valid` per request, at least 1 cycle later.
  - At most one request is outstanding.
- **Request rule**
  - `imem_req` is asserted only when all of the following hold: state is IDLE, `count + 0 < DEPTH`, and `redirect` is low.
  - On issue, `imem_addr = fetch_pc`, `fetch_pc` advances by 2 (16-bit wrap: 16'hFFFE -> 16'h0000), and state becomes WAIT.
- **States**
  - IDLE: no request outstanding.
  - WAIT: one request outstanding. On `imem_valid`, push `{addr, rdata}` and return to IDLE.
  - DROP: one stale request outstanding. On `imem_valid`, discard the data and return to IDLE.
- **Queue**
  - `en = (count != 0)`.
  - `inst`/`inst_pc` show the head; both are 16'h0000 when the queue is empty.
  - The head is popped when `en && inst_ready`.
  - Push and pop in the same cycle are both legal and leave `count` unchanged.
- **Redirect (highest priority)**
  - `fetch_pc <= {redirect_pc[15:1], 1'b0}` and the queue is cleared.
  - A pop in the same cycle is still counted as consumed.
  - If in WAIT with no `imem_valid` this cycle: go to DROP.
  - If in WAIT with `imem_valid` this cycle: discard the response and go to IDLE.
  - If in DROP: stay in DROP, with the new `fetch_pc`.
  - `imem_req` is 0 in the redirect cycle.
- The instruction word is never interpreted; 16'hFFFF (trap) and illegal encodings pass through unchanged.

## Timing
- **Reset values**
  - `imem_req` 0, `imem_addr` `RESET_PC`, `en` 0, `inst` 0, `inst_pc` 0.
  - State IDLE, count 0, `fetch_pc` `RESET_PC`.
- **First fetch**
  - `imem_req` is asserted in the first cycle after `rst_n` rises.
  - Fetch-to-decode latency: `en` rises the cycle after `imem_valid`, because the queue is registered.
- **Throughput**
  - Memory latency L gives one request every L+1 cycles.
  - Requests stop when the queue is full with a stalled consumer.
  - `imem_addr` holds its last value when `imem_req` is 0.
- **Redirect**
  - `en` is 0 in the cycle after a redirect.
  - The first request to the new PC goes out in the cycle after the redirect if the state is IDLE, otherwise in the cycle after the stale response.
- Reset asserted mid-operation clears everything asynchronously. A response arriving after reset released from a pre-reset request is out of contract.

## Structure
- Shared package (`fetch_pkg`): state enum `{S_IDLE, S_WAIT, S_DROP}`, `PC_STEP = 16'd2`, and the queue entry struct `{pc[15:0], inst[15:0]}`.
- Sub-module `fetch_fifo`:
  - Parameterised `DEPTH`, with push, pop, flush, count, and head data.
  - Flush has priority over push.
- The top level holds the FSM, `fetch_pc`, and request and discard control.

## Test plan
- Reset release, memory L=1, `inst_ready`=1 → requests at 0x0000, 0x0002, 0x0004 every 2 cycles; `en`/`inst_pc` follow 2 cycles after each request with the matching `imem_rdata`.
- `inst_ready`=0 for 10 cycles, L=1 → exactly `DEPTH` words buffered, then `imem_req` stays 0; on release, words pop in order 0x0000, 0x0002 and fetching resumes at 0x0004.
- Redirect to 0x0101 while in WAIT, L=3 → stale response dropped (never seen on `en`); next `imem_addr` = 0x0100.
- Redirect in the same cycle as `imem_valid` → response discarded, no DROP state, request to the target on the next cycle.
- `RESET_PC`=16'hFFFE, L=1 → fetch addresses 0xFFFE, 0x0000, 0x0002.
- `rst_n` pulsed low while in WAIT with 1 entry queued → all outputs return to reset values within the low phase; first request after release is at `RESET_PC`.
